// File: rtl/fifo_router.sv
// fifo_router: round-robin router from NUM_IN FWFT input FIFOs to NUM_OUT output FIFOs, steered by a per-word dest field.
// Latency: pop is combinational in cycle t, the word is pushed (registered) in t+1; one word per cycle sustained.
// Backpressure: inputs whose destination reports almost_full are skipped, others keep flowing; enable low blocks new grants.
module fifo_router #(
  parameter int DATA_W   = 10,
  parameter int NUM_IN   = 4,
  parameter int NUM_OUT  = 4,
  parameter int DEST_LSB = 8,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [NUM_IN*DATA_W-1:0]     fifo_out,
  input  logic [NUM_IN-1:0]            fifo_empty,
  output logic [NUM_IN-1:0]            fifo_pop,
  output logic [NUM_OUT*DATA_W-1:0]    fifo_in,
  output logic [NUM_OUT-1:0]           fifo_push,
  input  logic [NUM_OUT-1:0]           fifo_almost_full,
  output logic [$clog2(NUM_IN)-1:0]    grant_id,
  output logic [NUM_OUT*CNT_W-1:0]     fwd_count
);

  localparam int DW = $clog2(NUM_OUT);
  localparam int IW = $clog2(NUM_IN);

  logic [IW-1:0]     rr_ptr;
  logic [NUM_IN-1:0] elig;
  logic              win_vld;
  logic [IW-1:0]     win_idx;
  logic [DATA_W-1:0] win_word;
  logic [DW-1:0]     win_dest;

  // Per-input eligibility: enabled, head present, destination exists and has room.
  always_comb begin
    logic [DW-1:0] d;
    d    = '0;
    elig = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      d = fifo_out[i*DATA_W + DEST_LSB +: DW];
      // An out-of-range destination never becomes eligible; that input stalls in place.
      if (enable && !fifo_empty[i] && (int'(d) < NUM_OUT))
        elig[i] = !fifo_almost_full[d];
    end
  end

  // Round-robin search upward from rr_ptr; the first eligible input wins.
  always_comb begin
    int idx;
    idx     = 0;
    win_vld = 1'b0;
    win_idx = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_IN;
      if (!win_vld && elig[idx]) begin
        win_vld = 1'b1;
        win_idx = IW'(idx);
      end
    end
    win_word = fifo_out[int'(win_idx)*DATA_W +: DATA_W];
    win_dest = win_word[DEST_LSB +: DW];
  end

  // Pop is held off while reset is high so no word leaves an input FIFO during reset.
  assign fifo_pop = (win_vld && !reset) ? (NUM_IN'(1) << win_idx) : '0;

  // Register the winning word onto its output lane (idle lanes read 0) and advance arbitration/counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_in   <= '0;
      fifo_push <= '0;
      rr_ptr    <= '0;
      grant_id  <= '0;
      fwd_count <= '0;
    end else begin
      fifo_in   <= '0;
      fifo_push <= '0;
      if (win_vld) begin
        fifo_in[int'(win_dest)*DATA_W +: DATA_W] <= win_word;
        fifo_push[win_dest]                      <= 1'b1;
        rr_ptr   <= (int'(win_idx) == NUM_IN-1) ? '0 : win_idx + 1'b1;
        grant_id <= win_idx;
        // Counter wraps naturally at 2^CNT_W.
        fwd_count[int'(win_dest)*CNT_W +: CNT_W] <= fwd_count[int'(win_dest)*CNT_W +: CNT_W] + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_router.sv
// tb_fifo_router: table vectors, hand sequences and random traffic against a queue-based reference model.
// Latency: model predicts combinational pop each cycle and the registered push/lanes one cycle later.
// Backpressure: random almost_full and enable patterns exercise skipping and stalls.
module tb_fifo_router;

  localparam int DATA_W   = 10;
  localparam int NUM_IN   = 4;
  localparam int NUM_OUT  = 4;
  localparam int DEST_LSB = 8;
  localparam int CNT_W    = 4;

  localparam logic [39:0] W_F = {10'h300, 10'h200, 10'h100, 10'h000};
  localparam logic [39:0] W_B = {10'h000, 10'h000, 10'h100, 10'h200};

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      enable;
  logic [NUM_IN*DATA_W-1:0]  fifo_out;
  logic [NUM_IN-1:0]         fifo_empty;
  logic [NUM_IN-1:0]         fifo_pop;
  logic [NUM_OUT*DATA_W-1:0] fifo_in;
  logic [NUM_OUT-1:0]        fifo_push;
  logic [NUM_OUT-1:0]        fifo_almost_full;
  logic [1:0]                grant_id;
  logic [NUM_OUT*CNT_W-1:0]  fwd_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          m_rr;
  int          m_grant;
  int          m_cnt [NUM_OUT];
  logic [3:0]  m_push;
  logic [39:0] m_in;
  logic [9:0]  q [NUM_IN][$];

  typedef struct {
    logic [39:0] words;
    logic [3:0]  empty;
    logic [3:0]  af;
    logic        en;
    logic [3:0]  exp_pop;
  } vec_t;

  vec_t tbl [17];

  fifo_router #(
    .DATA_W(DATA_W), .NUM_IN(NUM_IN), .NUM_OUT(NUM_OUT), .DEST_LSB(DEST_LSB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_out(fifo_out), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_in(fifo_in), .fifo_push(fifo_push), .fifo_almost_full(fifo_almost_full),
    .grant_id(grant_id), .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_rr = 0;
    m_grant = 0;
    m_push = '0;
    m_in = '0;
    for (int i = 0; i < NUM_OUT; i++) m_cnt[i] = 0;
  endtask

  function automatic logic [15:0] pack_cnt();
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < NUM_OUT; i++) r[i*CNT_W +: CNT_W] = 4'(m_cnt[i]);
    return r;
  endfunction

  // Winner by rule: scan inputs starting at the round-robin pointer, take the first that can move.
  function automatic int model_winner();
    int w;
    int i;
    int d;
    w = -1;
    if (reset || !enable) return -1;
    for (int k = 0; k < NUM_IN; k++) begin
      i = (m_rr + k) % NUM_IN;
      d = int'(fifo_out[i*DATA_W + DEST_LSB +: 2]);
      if (w < 0 && !fifo_empty[i] && d < NUM_OUT && !fifo_almost_full[d]) w = i;
    end
    return w;
  endfunction

  // One clock: check pop and registered outputs against the model, then advance the model.
  task automatic cycle(output int w);
    logic [9:0] word;
    int d;
    if (reset) model_clear();
    w = model_winner();
    word = '0;
    if (w >= 0) word = fifo_out[w*DATA_W +: DATA_W];
    d = int'(word[9:8]);
    @(negedge clk);
    chk("pop", fifo_pop, (w >= 0) ? (64'd1 << w) : 64'd0);
    chk("push", fifo_push, m_push);
    chk("lanes", fifo_in, m_in);
    chk("grant", grant_id, m_grant);
    chk("count", fwd_count, pack_cnt());
    @(posedge clk);
    if (reset) begin
      model_clear();
    end else begin
      m_push = '0;
      m_in = '0;
      if (w >= 0) begin
        m_push[d] = 1'b1;
        m_in[d*DATA_W +: DATA_W] = word;
        m_rr = (w + 1) % NUM_IN;
        m_grant = w;
        m_cnt[d] = (m_cnt[d] + 1) % (1 << CNT_W);
      end
    end
    #1;
  endtask

  initial begin
    int w;
    //            words  empty     af        en    exp_pop
    tbl[0]  = '{W_F, 4'b0000, 4'b0000, 1'b1, 4'b0001};
    tbl[1]  = '{W_F, 4'b0000, 4'b0000, 1'b1, 4'b0010};
    tbl[2]  = '{W_F, 4'b0000, 4'b0000, 1'b1, 4'b0100};
    tbl[3]  = '{W_F, 4'b0000, 4'b0000, 1'b1, 4'b1000};
    tbl[4]  = '{W_F, 4'b0000, 4'b0000, 1'b1, 4'b0001};
    tbl[5]  = '{W_F, 4'b0111, 4'b0000, 1'b1, 4'b1000};
    tbl[6]  = '{W_B, 4'b1100, 4'b0100, 1'b1, 4'b0010};
    tbl[7]  = '{W_B, 4'b1100, 4'b0000, 1'b1, 4'b0001};
    tbl[8]  = '{W_F, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    tbl[9]  = '{W_F, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    tbl[10] = '{W_F, 4'b0000, 4'b0000, 1'b0, 4'b0000};
    tbl[11] = '{W_F, 4'b0000, 4'b0000, 1'b1, 4'b0010};
    tbl[12] = '{W_F, 4'b0000, 4'b1111, 1'b1, 4'b0000};
    tbl[13] = '{W_F, 4'b1111, 4'b0000, 1'b1, 4'b0000};
    tbl[14] = '{W_F, 4'b0000, 4'b1011, 1'b1, 4'b0100};
    tbl[15] = '{W_F, 4'b0000, 4'b0001, 1'b1, 4'b1000};
    tbl[16] = '{W_F, 4'b0000, 4'b0001, 1'b1, 4'b0010};

    model_clear();
    reset = 1'b1;
    enable = 1'b1;
    fifo_out = W_F;
    fifo_empty = 4'b0000;
    fifo_almost_full = 4'b0000;

    // Reset held with traffic waiting: nothing moves.
    @(posedge clk);
    #1;
    chk("rst_pop", fifo_pop, 4'b0000);
    chk("rst_push", fifo_push, 4'b0000);
    chk("rst_lanes", fifo_in, 40'h0);
    chk("rst_count", fwd_count, 16'h0);
    chk("rst_grant", grant_id, 2'd0);
    cycle(w);
    cycle(w);
    reset = 1'b0;

    // Fairness, back-pressure, enable and almost_full vectors.
    for (int v = 0; v < 17; v++) begin
      fifo_out = tbl[v].words;
      fifo_empty = tbl[v].empty;
      fifo_almost_full = tbl[v].af;
      enable = tbl[v].en;
      #1;
      chk($sformatf("vec%0d_pop", v), fifo_pop, tbl[v].exp_pop);
      cycle(w);
    end

    // Counter wrap: 17 words to output 3 from a clean state.
    reset = 1'b1;
    cycle(w);
    reset = 1'b0;
    enable = 1'b1;
    fifo_almost_full = 4'b0000;
    fifo_out = {10'h3AB, 30'h0};
    fifo_empty = 4'b0111;
    for (int n = 0; n < 17; n++) cycle(w);
    chk("wrap_cnt3", fwd_count[15:12], 4'd1);
    chk("wrap_others", fwd_count[11:0], 12'h0);
    chk("wrap_lane3", fifo_in[39:30], 10'h3AB);

    // Reset the cycle after a pop: the in-flight word is dropped.
    fifo_out = {20'h0, 10'h155, 10'h0};
    fifo_empty = 4'b1101;
    cycle(w);
    chk("mid_push_before", fifo_push, 4'b0010);
    chk("mid_lane_before", fifo_in[19:10], 10'h155);
    reset = 1'b1;
    #1;
    chk("mid_push", fifo_push, 4'b0000);
    chk("mid_lanes", fifo_in, 40'h0);
    chk("mid_grant", grant_id, 2'd0);
    chk("mid_count", fwd_count, 16'h0);
    chk("mid_pop", fifo_pop, 4'b0000);
    cycle(w);
    reset = 1'b0;
    fifo_out = W_F;
    fifo_empty = 4'b0000;
    cycle(w);
    chk("post_rst_grant", grant_id, 2'd0);
    chk("post_rst_push", fifo_push, 4'b0001);

    // Random traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_IN; i++)
        if ($urandom_range(0, 2) == 0 && q[i].size() < 4) q[i].push_back(10'($urandom));
      for (int i = 0; i < NUM_IN; i++) begin
        fifo_empty[i] = (q[i].size() == 0);
        fifo_out[i*DATA_W +: DATA_W] = (q[i].size() != 0) ? q[i][0] : 10'h0;
      end
      fifo_almost_full = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      enable = ($urandom_range(0, 9) != 0);
      cycle(w);
      if (w >= 0) void'(q[w].pop_front());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_router.md
# fifo_router

Parametrised round-robin router between NUM_IN first-word-fall-through input FIFOs and NUM_OUT output FIFOs. It is the successor of the fixed 4x4 demux/mux routing stage in the FIFO datapath. Each word carries its own destination field, so no external dest select is needed. Only one word moves per cycle, input arbitration is round-robin, back-pressure from the output FIFOs is honoured, and the block keeps per-output forwarded-word counters.

## Interface
Parameters:
- DATA_W, 10, word width including the destination field.
- NUM_IN, 4, number of input FIFOs (2..16).
- NUM_OUT, 4, number of output FIFOs (2..16).
- DEST_LSB, 8, bit position of the destination field. The field is DW = clog2(NUM_OUT) bits, at word[DEST_LSB +: DW].
- CNT_W, 16, width of each per-output counter.

Ports:
- clk, in, 1: the single clock, rising edge.
- reset, in, 1: asynchronous, active-high; clears all state.
- enable, in, 1: when low, no grants are made; an in-flight push still completes.
- fifo_out, in, NUM_IN*DATA_W: head word of each input FIFO; input i is at [i*DATA_W +: DATA_W].
- fifo_empty, in, NUM_IN: input FIFO empty flags.
- fifo_pop, out, NUM_IN: combinational one-hot pop to the input FIFOs.
- fifo_in, out, NUM_OUT*DATA_W: registered words to the output FIFOs.
- fifo_push, out, NUM_OUT: registered one-hot push to the output FIFOs.
- fifo_almost_full, in, NUM_OUT: asserted by an output FIFO when it has ≤1 free entry.
- grant_id, out, clog2(NUM_IN): index of the last granted input.
- fwd_count, out, NUM_OUT*CNT_W: per-output count of words forwarded.

## Operation
- Destination of input i: d_i = fifo_out_i[DEST_LSB +: DW]. Input i is eligible when all of the following hold:
  - enable = 1;
  - fifo_empty[i] = 0;
  - d_i < NUM_OUT;
  - fifo_almost_full[d_i] = 0.
- Arbitration:
  - Search starts at rr_ptr and goes upward modulo NUM_IN.
  - The first eligible input wins, and fifo_pop[winner] is asserted that same cycle.
  - At most one pop bit is set per cycle.
- Winner handling on the clock edge:
  - Capture fifo_in[d] <= word and fifo_push[d] <= 1.
  - Drive all other fifo_in lanes to 0 and all other push bits to 0, so idle lanes always read 0.
  - Set rr_ptr <= (winner+1) mod NUM_IN and grant_id <= winner.
  - Increment fwd_count[d]; it wraps from 2^CNT_W-1 to 0.
- No eligible input: all push bits and all fifo_in lanes are 0 the next cycle; rr_ptr and grant_id hold.
- Input with d_i ≥ NUM_OUT (possible only when NUM_OUT is not a power of two): the input is never eligible and stalls in place. It is not dropped; software must flush it.
- An input blocked by almost_full is skipped without stalling other inputs. There is no head-of-line blocking across inputs.
- Reset values:
  - fifo_push = 0, fifo_in = 0, rr_ptr = 0, grant_id = 0, all fwd_count = 0.
  - fifo_pop = 0 while reset is high; pop is gated by !reset.
- Reset asserted mid-operation: the registered word and push are cleared immediately, so a word popped in the preceding cycle but not yet pushed is lost. This is accepted behaviour.

## Timing
- Pop to push latency: 1 cycle. A word popped in cycle t appears with fifo_push at cycle t+1.
- Throughput: 1 word per cycle sustained, across any mix of inputs and outputs.
- The almost_full threshold covers the single in-flight word. Consecutive grants to the same output are legal while almost_full stays low.
- enable falling in cycle t: no pop in t. A push already registered from t-1 still appears in t.
- The fifo_empty, fifo_out and fifo_almost_full to fifo_pop path is combinational. The input FIFOs must present their head word without latency.

## Test plan
- Reset: hold reset with all inputs non-empty → fifo_pop = 0, fifo_push = 0, fifo_in = 0, counters 0. Deassert → first grant goes to input 0.
- Round-robin fairness: all 4 inputs non-empty with words 0x000, 0x100, 0x200, 0x300 (dests 0, 1, 2, 3) → grants 0, 1, 2, 3, 0; push[0..3] one-hot on cycles 1..4 with matching words; other lanes 0.
- Back-pressure: almost_full[2] = 1; input 0 holds dest 2, input 1 holds dest 1 → input 0 is skipped, input 1 is forwarded. Release almost_full[2] → input 0 is forwarded on the next grant.
- Enable: drop enable for 3 cycles with traffic pending → no pops during those cycles. The in-flight push completes in the first cycle; traffic resumes from rr_ptr after enable returns.
- Counter wrap: CNT_W = 4, send 17 words to output 3 → fwd_count[3] = 1, other counters unchanged.
- Mid-operation reset: assert reset the cycle after a pop → push is cleared immediately and no word appears on fifo_in; all state is back at reset values.
